// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time,
// holds the fetched word for decode and absorbs in-flight reads on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        protoErr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] target;
  logic        take_rsp;
  logic        consume;
  logic        stray_rsp;

  assign target = {redirectPc[31:2], 2'b00};
  assign take_rsp = (state == WAIT) && imemValid && !redirect;
  assign consume = (state == HOLD) && instrReady && !redirect;
  assign stray_rsp = imemValid && ((state == FETCH) || (state == HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect only returns to FETCH once no read is left outstanding.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        state_nxt = redirect ? FLUSH : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = imemValid ? FETCH : FLUSH;
        end else if (imemValid) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect || instrReady) begin
          state_nxt = FETCH;
        end
      end
      FLUSH: begin
        if (imemValid) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imemReq = 1'b0;
    instrValid = 1'b0;
    unique case (state)
      FETCH:   imemReq = 1'b1;
      HOLD:    instrValid = 1'b1;
      default: ;
    endcase
  end

  assign imemAddr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (consume) begin
      pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= 32'd0;
    end else if (take_rsp) begin
      instr <= imemRdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protoErr <= 1'b0;
    end else if (stray_rsp) begin
      protoErr <= 1'b1;
    end
  end

endmodule
